// File: rtl/mix_bist_pkg.sv
// ---------------------------------------------------------------------------
// mix_bist_pkg
// Shared types, widths and helpers for the mix core BIST sequencer.
// Contents:
//   bist_state_e  - sequencer states
//   CORE_IN_W / CORE_OUT_W - widths of the mix core stimulus / response
//   LFSR_W, LFSR_TAP_HI/LO - Fibonacci LFSR x^7+x^6+1 geometry
//   MISR_W, MISR_POLY      - 8-bit signature register geometry
//   lfsrNext()             - one LFSR step
// ---------------------------------------------------------------------------
package mix_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        APPLY,
        CAPTURE,
        COMPARE,
        DONE
    } bist_state_e;

    localparam int CORE_IN_W   = 7;
    localparam int CORE_OUT_W  = 3;

    localparam int LFSR_W      = 7;
    localparam int LFSR_TAP_HI = 6;
    localparam int LFSR_TAP_LO = 5;

    localparam int MISR_W      = 8;
    localparam logic [MISR_W-1:0] MISR_POLY = 8'h1D;

    // Shift left and feed back the XOR of the two top taps, which gives
    // the maximal-length (127-state) sequence 01,02,04,...,20,41,03,...
    function automatic logic [LFSR_W-1:0] lfsrNext(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], l[LFSR_TAP_HI] ^ l[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/mix_misr.sv
// ---------------------------------------------------------------------------
// mix_misr
// 8-bit multiple-input signature register compacting the 3-bit mix core
// response. Clear has priority over enable.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset (signature -> 0)
//   clear    in   zero the signature at the next edge
//   enable   in   fold data_in into the signature at the next edge
//   data_in  in   [2:0] core response
//   sig      out  [7:0] current signature
// ---------------------------------------------------------------------------
module mix_misr
    import mix_bist_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [CORE_OUT_W-1:0] data_in,
    output logic [MISR_W-1:0]     sig
);

    logic [MISR_W-1:0] sig_q;
    logic [MISR_W-1:0] sig_d;

    // Next signature: shift left, reduce by the polynomial when the MSB
    // falls off, then XOR the response into the low bits.
    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = '0;
        end else if (enable) begin
            sig_d = {sig_q[MISR_W-2:0], 1'b0}
                  ^ (sig_q[MISR_W-1] ? MISR_POLY : '0)
                  ^ {{(MISR_W-CORE_OUT_W){1'b0}}, data_in};
        end
    end

    // Signature storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/mix_bist_ctrl.sv
// ---------------------------------------------------------------------------
// mix_bist_ctrl
// BIST sequencer for the 7-in/3-out mix core. Drives the core from an
// exhaustive counter or an LFSR, holds each pattern for SETTLE_CYC cycles,
// compacts the response into an 8-bit MISR and compares the final
// signature with GOLDEN_SIG.
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   synchronous active-low reset
//   start          in   begin a run (only looked at in IDLE)
//   abort          in   cancel a run from any state
//   mode           in   0 = exhaustive, 1 = LFSR; latched at start
//   core_in        out  [6:0] stimulus to the core
//   core_out       in   [2:0] response from the core
//   busy           out  high from LOAD through COMPARE
//   done           out  one-cycle pulse while in DONE
//   pass           out  signature matched GOLDEN_SIG (valid from done)
//   signature      out  [7:0] current MISR value
//   pattern_count  out  [7:0] patterns captured in this run
// ---------------------------------------------------------------------------
module mix_bist_ctrl
    import mix_bist_pkg::*;
#(
    parameter int                N_PATTERNS = 128,
    parameter int                SETTLE_CYC = 1,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 7'h01,
    parameter logic [MISR_W-1:0] GOLDEN_SIG = 8'h00
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  mode,
    output logic [CORE_IN_W-1:0]  core_in,
    input  logic [CORE_OUT_W-1:0] core_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [MISR_W-1:0]     signature,
    output logic [7:0]            pattern_count
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 01.
    localparam logic [LFSR_W-1:0] SEED_EFF    = (LFSR_SEED == '0) ? 7'h01 : LFSR_SEED;
    localparam logic [7:0]        LAST_COUNT  = 8'(N_PATTERNS);
    localparam logic [15:0]       SETTLE_LAST = 16'(SETTLE_CYC - 1);

    bist_state_e          state_q;
    logic                 mode_q;
    logic [LFSR_W-1:0]    lfsr_q;
    logic [7:0]           patCount_q;
    logic [15:0]          settleCnt_q;
    logic [CORE_IN_W-1:0] coreIn_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;

    logic                 startAccept;
    logic                 settleDone;
    logic                 captureEn;
    logic [CORE_IN_W-1:0] curPattern;
    logic [MISR_W-1:0]    sigVal;

    // Abort beats start in IDLE. A capture happens on the edge that leaves
    // the last settle cycle, i.e. the edge that enters CAPTURE, so the MISR
    // sees the response to the pattern that was held through APPLY.
    assign startAccept = (state_q == IDLE) && start && !abort;
    assign settleDone  = (settleCnt_q == SETTLE_LAST);
    assign captureEn   = (state_q == APPLY) && settleDone && !abort;

    // In exhaustive mode the capture count doubles as the pattern; its low
    // seven bits wrap naturally when more than 128 patterns are requested.
    assign curPattern  = mode_q ? lfsr_q : patCount_q[CORE_IN_W-1:0];

    mix_misr u_misr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (startAccept),
        .enable  (captureEn),
        .data_in (core_out),
        .sig     (sigVal)
    );

    // Sequencer. All outputs are registered here and change together with
    // the state: core_in is loaded on entry to APPLY and held through
    // CAPTURE, then zeroed for COMPARE/DONE. Abort drops straight to IDLE
    // from any active state while leaving the signature and count as they
    // were, so a teammate can inspect how far the run got.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            lfsr_q      <= SEED_EFF;
            patCount_q  <= '0;
            settleCnt_q <= '0;
            coreIn_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else if (abort && (state_q != IDLE)) begin
            state_q     <= IDLE;
            settleCnt_q <= '0;
            coreIn_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (startAccept) begin
                        state_q    <= LOAD;
                        mode_q     <= mode;
                        lfsr_q     <= SEED_EFF;
                        patCount_q <= '0;
                        busy_q     <= 1'b1;
                        pass_q     <= 1'b0;
                    end
                end
                LOAD: begin
                    state_q     <= APPLY;
                    coreIn_q    <= curPattern;
                    settleCnt_q <= '0;
                end
                APPLY: begin
                    if (settleDone) begin
                        state_q    <= CAPTURE;
                        patCount_q <= patCount_q + 8'd1;
                        lfsr_q     <= lfsrNext(lfsr_q);
                    end else begin
                        settleCnt_q <= settleCnt_q + 16'd1;
                    end
                end
                CAPTURE: begin
                    if (patCount_q == LAST_COUNT) begin
                        state_q  <= COMPARE;
                        coreIn_q <= '0;
                    end else begin
                        state_q     <= APPLY;
                        coreIn_q    <= curPattern;
                        settleCnt_q <= '0;
                    end
                end
                COMPARE: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (sigVal == GOLDEN_SIG);
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign core_in       = coreIn_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign signature     = sigVal;
    assign pattern_count = patCount_q;

endmodule

// File: tb/tb_mix_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mix_bist_ctrl
// Self-checking bench for mix_bist_ctrl. A behavioural stand-in for the mix
// core maps core_in to core_out through a lookup table, and a reference
// model rebuilds the expected pattern list and signature with plain
// arithmetic. A small second instance covers a short run with a long
// settle time and a zero LFSR seed.
// ---------------------------------------------------------------------------
module tb_mix_bist_ctrl;

    localparam int NV = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       mode = 1'b0;
    logic [6:0] coreIn;
    logic [2:0] coreOut;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] signature;
    logic [7:0] patternCount;

    logic       startS = 1'b0;
    logic       abortS = 1'b0;
    logic       modeS = 1'b1;
    logic [2:0] coreOutS = 3'b001;
    logic [6:0] coreInS;
    logic       busyS;
    logic       doneS;
    logic       passS;
    logic [7:0] signatureS;
    logic [7:0] patternCountS;

    logic [2:0] respTable [128];
    logic [2:0] respBank [NV][128];

    typedef struct {
        logic       mode;
        int         pulseAt;
        logic [7:0] expSig;
        logic       expPass;
        int         expBusy;
    } vec_t;
    vec_t vecs [NV];

    int         checks = 0;
    int         errors = 0;
    logic [6:0] capQ [$];
    int         busyCycles;
    int         doneCycles;
    bit         timedOut;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Behavioural stand-in for the mix core: a pure lookup on the stimulus.
    assign coreOut = respTable[coreIn];

    mix_bist_ctrl #(
        .N_PATTERNS (128),
        .SETTLE_CYC (1),
        .LFSR_SEED  (7'h01),
        .GOLDEN_SIG (8'h00)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .mode          (mode),
        .core_in       (coreIn),
        .core_out      (coreOut),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .signature     (signature),
        .pattern_count (patternCount)
    );

    mix_bist_ctrl #(
        .N_PATTERNS (2),
        .SETTLE_CYC (3),
        .LFSR_SEED  (7'h00),
        .GOLDEN_SIG (8'h03)
    ) dutSmall (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (startS),
        .abort         (abortS),
        .mode          (modeS),
        .core_in       (coreInS),
        .core_out      (coreOutS),
        .busy          (busyS),
        .done          (doneS),
        .pass          (passS),
        .signature     (signatureS),
        .pattern_count (patternCountS)
    );

    // One comparison: count it, and report it if the values differ.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // i-th pattern the generator should present, from the generator rules.
    function automatic logic [6:0] expPattern(input logic m, input int i, input logic [6:0] seed);
        int l;
        if (!m) return 7'(i % 128);
        l = (seed == 7'h00) ? 1 : int'(seed);
        for (int k = 0; k < i; k++) begin
            l = ((l * 2) % 128) + (((l / 64) ^ (l / 32)) % 2);
        end
        return 7'(l);
    endfunction

    // Expected signature after n captures with response bank v.
    function automatic logic [7:0] modelSig(input int v, input logic m, input int n, input logic [6:0] seed);
        int s;
        int p;
        s = 0;
        for (int i = 0; i < n; i++) begin
            p = int'(expPattern(m, i, seed));
            s = ((s * 2) % 256) ^ ((s >= 128) ? 29 : 0) ^ int'(respBank[v][p]);
        end
        return 8'(s);
    endfunction

    // Start a run on the main instance; returns at the first busy cycle.
    task automatic applyStimulus(input logic m);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Follow a run until done, recording busy length and captured patterns.
    // Optionally pulses start and flips mode mid-run at cycle pulseAt.
    task automatic monitorRun(input int pulseAt);
        logic [7:0] prevCount;
        busyCycles = 0;
        doneCycles = 0;
        timedOut   = 1'b1;
        capQ.delete();
        prevCount = patternCount;
        for (int c = 0; c < 2000; c++) begin
            if (busy) busyCycles++;
            if (patternCount != prevCount) capQ.push_back(coreIn);
            prevCount = patternCount;
            if (done) begin
                doneCycles++;
                timedOut = 1'b0;
                break;
            end
            start = (c == pulseAt);
            if (c == pulseAt) mode = ~mode;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Main test sequence.
    initial begin
        logic [6:0] lfsrRef [8];
        int         bad;
        int         cnt;
        logic [6:0] capS [$];
        logic [7:0] prevS;

        lfsrRef = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};

        for (int i = 0; i < 128; i++) begin
            respTable[i]   = 3'b000;
            respBank[0][i] = 3'b000;
            respBank[1][i] = 3'b000;
            respBank[2][i] = 3'b001;
            respBank[3][i] = 3'($urandom_range(7));
            respBank[4][i] = 3'($urandom_range(7));
            respBank[5][i] = 3'($urandom_range(7));
        end

        vecs[0] = '{1'b0, -1, 8'h00, 1'b1, 258};
        vecs[1] = '{1'b1, -1, 8'h00, 1'b1, 258};
        vecs[2] = '{1'b0, -1, modelSig(2, 1'b0, 128, 7'h01), 1'b0, 258};
        vecs[3] = '{1'b0, -1, modelSig(3, 1'b0, 128, 7'h01), 1'b0, 258};
        vecs[4] = '{1'b1, -1, modelSig(4, 1'b1, 128, 7'h01), 1'b0, 258};
        vecs[5] = '{1'b1, 37, modelSig(5, 1'b1, 128, 7'h01), 1'b0, 258};
        for (int v = 2; v < NV; v++) vecs[v].expPass = (vecs[v].expSig == 8'h00);

        // Reset held with start asserted: everything stays at zero.
        rst_n  = 1'b0;
        start  = 1'b1;
        startS = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst done", 32'(done), 32'd0);
        checkOutput("rst pass", 32'(pass), 32'd0);
        checkOutput("rst core_in", 32'(coreIn), 32'd0);
        checkOutput("rst signature", 32'(signature), 32'd0);
        checkOutput("rst count", 32'(patternCount), 32'd0);
        start  = 1'b0;
        startS = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);

        // Table-driven full runs.
        for (int v = 0; v < NV; v++) begin
            respTable = respBank[v];
            applyStimulus(vecs[v].mode);
            checkOutput($sformatf("v%0d busy after start", v), 32'(busy), 32'd1);
            monitorRun(vecs[v].pulseAt);
            checkOutput($sformatf("v%0d timeout", v), 32'(timedOut), 32'd0);
            checkOutput($sformatf("v%0d busy cycles", v), 32'(busyCycles), 32'(vecs[v].expBusy));
            checkOutput($sformatf("v%0d signature", v), 32'(signature), 32'(vecs[v].expSig));
            checkOutput($sformatf("v%0d pass", v), 32'(pass), 32'(vecs[v].expPass));
            checkOutput($sformatf("v%0d count", v), 32'(patternCount), 32'd128);
            checkOutput($sformatf("v%0d captures", v), 32'(capQ.size()), 32'd128);
            bad = 0;
            for (int i = 0; i < capQ.size(); i++) begin
                if (capQ[i] !== expPattern(vecs[v].mode, i, 7'h01)) bad++;
            end
            checkOutput($sformatf("v%0d bad patterns", v), 32'(bad), 32'd0);
            if (vecs[v].mode && capQ.size() >= 8) begin
                bad = 0;
                for (int i = 0; i < 8; i++) if (capQ[i] !== lfsrRef[i]) bad++;
                checkOutput($sformatf("v%0d lfsr head", v), 32'(bad), 32'd0);
            end
            @(negedge clk);
            checkOutput($sformatf("v%0d done width", v), 32'(done), 32'd0);
            checkOutput($sformatf("v%0d idle busy", v), 32'(busy), 32'd0);
            checkOutput($sformatf("v%0d idle core_in", v), 32'(coreIn), 32'd0);
            checkOutput($sformatf("v%0d pass held", v), 32'(pass), 32'(vecs[v].expPass));
        end

        // Abort after the fifth capture.
        respTable = respBank[3];
        applyStimulus(1'b0);
        cnt = 0;
        while (patternCount != 8'd5 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("abort reach 5", 32'(patternCount), 32'd5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort pass", 32'(pass), 32'd0);
        checkOutput("abort core_in", 32'(coreIn), 32'd0);
        checkOutput("abort count", 32'(patternCount), 32'd5);
        checkOutput("abort signature", 32'(signature), 32'(modelSig(3, 1'b0, 5, 7'h01)));
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        checkOutput("abort stays idle", 32'(cnt), 32'd0);

        // start and abort together in IDLE: abort wins, no LOAD happens.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start+abort busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("start+abort busy later", 32'(busy), 32'd0);
        checkOutput("start+abort count kept", 32'(patternCount), 32'd5);

        // Reset mid-run.
        applyStimulus(1'b1);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst busy", 32'(busy), 32'd0);
        checkOutput("midrst done", 32'(done), 32'd0);
        checkOutput("midrst pass", 32'(pass), 32'd0);
        checkOutput("midrst signature", 32'(signature), 32'd0);
        checkOutput("midrst count", 32'(patternCount), 32'd0);
        checkOutput("midrst core_in", 32'(coreIn), 32'd0);
        rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        checkOutput("midrst stays idle", 32'(cnt), 32'd0);

        // Short run, long settle, zero seed (replaced by 01), response 001.
        @(negedge clk);
        startS = 1'b1;
        @(negedge clk);
        startS = 1'b0;
        busyCycles = 0;
        timedOut = 1'b1;
        prevS = patternCountS;
        for (int c = 0; c < 200; c++) begin
            if (busyS) busyCycles++;
            if (patternCountS != prevS) capS.push_back(coreInS);
            prevS = patternCountS;
            if (doneS) begin
                timedOut = 1'b0;
                break;
            end
            @(negedge clk);
        end
        checkOutput("small timeout", 32'(timedOut), 32'd0);
        checkOutput("small busy cycles", 32'(busyCycles), 32'd10);
        checkOutput("small signature", 32'(signatureS), 32'h03);
        checkOutput("small count", 32'(patternCountS), 32'd2);
        checkOutput("small pass", 32'(passS), 32'd1);
        checkOutput("small captures", 32'(capS.size()), 32'd2);
        if (capS.size() == 2) begin
            checkOutput("small pattern0", 32'(capS[0]), 32'h01);
            checkOutput("small pattern1", 32'(capS[1]), 32'h02);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
